// File: rtl/pulpino_mbox_pkg.sv
// Shared definitions for the Pulpino-side USB mailbox: APB register word
// indices (PADDR[4:2]), STATUS bit positions and the count field layout.
package pulpino_mbox_pkg;

    // Register word index, i.e. byte offset >> 2
    typedef enum logic [2:0] {
        REG_RX_DATA   = 3'd0,
        REG_STATUS    = 3'd1,
        REG_TX_DATA   = 3'd2,
        REG_TX_FLAGS  = 3'd3,
        REG_EXT_FLAGS = 3'd4,
        REG_IRQ_EN    = 3'd5
    } reg_idx_e;

    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVERFLOW  = 2;
    localparam int unsigned ST_UNDERFLOW = 3;
    localparam int unsigned ST_COUNT_LSB = 8;
    localparam int unsigned ST_COUNT_W   = 5;

    function automatic logic reg_is_mapped(input logic [2:0] idx);
        return idx <= REG_IRQ_EN;
    endfunction

endpackage

// File: rtl/mbox_sync_fifo.sv
// Single-clock FIFO for received mailbox words.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   push_i, wdata_i     write request and data
//   pop_i               read request (head is dropped at the edge)
//   rdata_o             head word, 0 when empty
//   full_o, empty_o     occupancy flags
//   count_o             number of stored words, 0..pDEPTH
//   overflow_o          push refused this cycle (full, no pop)
//   underflow_o         pop refused this cycle (empty)
module mbox_sync_fifo #(
    parameter int unsigned pWIDTH = 32,
    parameter int unsigned pDEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  logic [pWIDTH-1:0]         wdata_i,
    input  logic                      pop_i,
    output logic [pWIDTH-1:0]         rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(pDEPTH):0]   count_o,
    output logic                      overflow_o,
    output logic                      underflow_o
);
    localparam int unsigned AW = $clog2(pDEPTH);
    localparam int unsigned CW = AW + 1;

    logic [pWIDTH-1:0] mem_q [pDEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(pDEPTH));
    assign count_o = count_q;

    // Both decisions use the pre-edge occupancy: a pop frees a slot for a
    // simultaneous push when full, but an empty FIFO cannot pop a word that
    // is only arriving this cycle.
    assign do_pop      = pop_i & ~empty_o;
    assign do_push     = push_i & (~full_o | do_pop);
    assign overflow_o  = push_i & ~do_push;
    assign underflow_o = pop_i & empty_o;

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Power-of-two depth: pointers wrap by natural overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pulpino_mailbox_apb.sv
// Pulpino-side end of the USB<->Pulpino mailbox. Words strobed in from the
// USB register block are queued in an RX FIFO and read by the core over APB;
// the core drives TX data/flags back toward the register block.
// Ports:
//   crypto_clk, reset_i           clock, synchronous active-high reset
//   usb_data_i, usb_data_valid_i  incoming word and level strobe (one push per rising edge)
//   ext_flags_i                   quasi-static flags from the USB domain
//   PADDR..PWDATA, PRDATA,
//   PREADY, PSLVERR               APB slave, zero wait states
//   pulpino_data_o, pulpino_flags_o  TX_DATA / TX_FLAGS registers
//   rx_irq_o                      registered IRQ_EN[0] & RX FIFO not empty
module pulpino_mailbox_apb
    import pulpino_mbox_pkg::*;
#(
    parameter int unsigned pFIFO_DEPTH = 4,
    parameter int unsigned pADDR_W     = 12
) (
    input  logic               crypto_clk,
    input  logic               reset_i,
    input  logic [31:0]        usb_data_i,
    input  logic               usb_data_valid_i,
    input  logic [31:0]        ext_flags_i,
    input  logic [pADDR_W-1:0] PADDR,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    output logic [31:0]        pulpino_data_o,
    output logic [31:0]        pulpino_flags_o,
    output logic               rx_irq_o
);
    localparam int unsigned CW = $clog2(pFIFO_DEPTH) + 1;

    logic        valid_q;
    logic        ovf_q, ovf_d, udf_q, udf_d;
    logic        irq_en_q, irq_en_d, rx_irq_q, rx_irq_d;
    logic [31:0] tx_data_q, tx_data_d, tx_flags_q, tx_flags_d;
    (* ASYNC_REG = "TRUE" *) logic [31:0] ext_sync1_q;
    (* ASYNC_REG = "TRUE" *) logic [31:0] ext_sync2_q;

    logic [2:0]    idx;
    logic          apb_access, apb_rd, apb_wr, status_w1c;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ovf, fifo_udf;
    logic [31:0]   fifo_rdata, status;
    logic [CW-1:0] fifo_count;
    logic          unused_addr_bits;

    assign idx              = PADDR[4:2];
    assign unused_addr_bits = ^{PADDR[pADDR_W-1:5], PADDR[1:0]};
    assign apb_access       = PSEL & PENABLE;
    assign apb_rd           = apb_access & ~PWRITE;
    assign apb_wr           = apb_access & PWRITE;
    assign status_w1c       = apb_wr & (idx == REG_STATUS);

    // Rising edge of the level strobe: exactly one push per strobe
    assign fifo_push = usb_data_valid_i & ~valid_q;
    assign fifo_pop  = apb_rd & (idx == REG_RX_DATA);

    mbox_sync_fifo #(
        .pWIDTH (32),
        .pDEPTH (pFIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i       (crypto_clk),
        .rst_i       (reset_i),
        .push_i      (fifo_push),
        .wdata_i     (usb_data_i),
        .pop_i       (fifo_pop),
        .rdata_o     (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .overflow_o  (fifo_ovf),
        .underflow_o (fifo_udf)
    );

    always_comb begin
        status                                = '0;
        status[ST_EMPTY]                      = fifo_empty;
        status[ST_FULL]                       = fifo_full;
        status[ST_OVERFLOW]                   = ovf_q;
        status[ST_UNDERFLOW]                  = udf_q;
        status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
    end

    always_comb begin
        PRDATA = '0;
        case (idx)
            REG_RX_DATA:   PRDATA = fifo_rdata;
            REG_STATUS:    PRDATA = status;
            REG_TX_DATA:   PRDATA = tx_data_q;
            REG_TX_FLAGS:  PRDATA = tx_flags_q;
            REG_EXT_FLAGS: PRDATA = ext_sync2_q;
            REG_IRQ_EN:    PRDATA = {31'd0, irq_en_q};
            default:       PRDATA = '0;
        endcase
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = apb_access & ~reg_is_mapped(idx);

    // Sticky bits: a new event in the same cycle as its W1C wins
    always_comb begin
        ovf_d      = (ovf_q & ~(status_w1c & PWDATA[ST_OVERFLOW])) | fifo_ovf;
        udf_d      = (udf_q & ~(status_w1c & PWDATA[ST_UNDERFLOW])) | fifo_udf;
        tx_data_d  = (apb_wr && idx == REG_TX_DATA)  ? PWDATA : tx_data_q;
        tx_flags_d = (apb_wr && idx == REG_TX_FLAGS) ? PWDATA : tx_flags_q;
        irq_en_d   = (apb_wr && idx == REG_IRQ_EN)   ? PWDATA[0] : irq_en_q;
        rx_irq_d   = irq_en_q & ~fifo_empty;
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            irq_en_q    <= 1'b0;
            rx_irq_q    <= 1'b0;
            tx_data_q   <= '0;
            tx_flags_q  <= '0;
            ext_sync1_q <= '0;
            ext_sync2_q <= '0;
        end else begin
            valid_q     <= usb_data_valid_i;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            irq_en_q    <= irq_en_d;
            rx_irq_q    <= rx_irq_d;
            tx_data_q   <= tx_data_d;
            tx_flags_q  <= tx_flags_d;
            ext_sync1_q <= ext_flags_i;
            ext_sync2_q <= ext_sync1_q;
        end
    end

    assign pulpino_data_o  = tx_data_q;
    assign pulpino_flags_o = tx_flags_q;
    assign rx_irq_o        = rx_irq_q;

endmodule

// File: tb/tb_pulpino_mailbox_apb.sv
// Scoreboard bench for pulpino_mailbox_apb: a queue-based reference model
// predicts each cycle's outputs; a monitor compares them against the DUT.
module tb_pulpino_mailbox_apb;
    localparam int DEPTH = 4;
    localparam int AW    = 12;

    logic          crypto_clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [31:0]   usb_data_i = '0;
    logic          usb_data_valid_i = 1'b0;
    logic [31:0]   ext_flags_i = '0;
    logic [AW-1:0] PADDR = '0;
    logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0]   PWDATA = '0;
    logic [31:0]   PRDATA;
    logic          PREADY, PSLVERR;
    logic [31:0]   pulpino_data_o, pulpino_flags_o;
    logic          rx_irq_o;

    always #5 crypto_clk = ~crypto_clk;

    pulpino_mailbox_apb #(.pFIFO_DEPTH(DEPTH), .pADDR_W(AW)) dut (
        .crypto_clk       (crypto_clk),
        .reset_i          (reset_i),
        .usb_data_i       (usb_data_i),
        .usb_data_valid_i (usb_data_valid_i),
        .ext_flags_i      (ext_flags_i),
        .PADDR            (PADDR),
        .PSEL             (PSEL),
        .PENABLE          (PENABLE),
        .PWRITE           (PWRITE),
        .PWDATA           (PWDATA),
        .PRDATA           (PRDATA),
        .PREADY           (PREADY),
        .PSLVERR          (PSLVERR),
        .pulpino_data_o   (pulpino_data_o),
        .pulpino_flags_o  (pulpino_flags_o),
        .rx_irq_o         (rx_irq_o)
    );

    typedef struct {
        bit        chk;
        bit        acc;
        bit        rd;
        bit [31:0] prdata;
        bit        slverr;
        bit [31:0] data_o;
        bit [31:0] flags_o;
        bit        irq;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state (value after the most recent clock edge)
    bit [31:0] m_fifo[$];
    bit        m_ovf, m_udf, m_irq_en, m_irq, m_prev, m_known;
    bit [31:0] m_tx, m_txf, m_s1, m_s2;

    function automatic bit [31:0] model_read(input bit [2:0] idx);
        bit [31:0] v;
        v = '0;
        case (idx)
            3'd0: v = (m_fifo.size() != 0) ? m_fifo[0] : 32'd0;
            3'd1: begin
                v[0]    = (m_fifo.size() == 0);
                v[1]    = (m_fifo.size() == DEPTH);
                v[2]    = m_ovf;
                v[3]    = m_udf;
                v[12:8] = 5'(m_fifo.size());
            end
            3'd2: v = m_tx;
            3'd3: v = m_txf;
            3'd4: v = m_s2;
            3'd5: v = {31'd0, m_irq_en};
            default: v = '0;
        endcase
        return v;
    endfunction

    // Model: inputs are stable at the falling edge; predict this cycle's
    // outputs, then advance the state across the coming rising edge.
    always @(negedge crypto_clk) begin
        exp_t     e;
        bit       acc, wr, popped;
        bit [2:0] idx;
        int       pre;
        acc       = PSEL && PENABLE;
        wr        = PWRITE;
        idx       = PADDR[4:2];
        e.chk     = m_known;
        e.acc     = acc;
        e.rd      = acc && !wr;
        e.prdata  = model_read(idx);
        e.slverr  = idx > 3'd5;
        e.data_o  = m_tx;
        e.flags_o = m_txf;
        e.irq     = m_irq;
        exp_q.push_back(e);
        if (reset_i) begin
            m_fifo.delete();
            m_ovf = 0; m_udf = 0; m_irq_en = 0; m_irq = 0; m_prev = 0;
            m_tx = 0; m_txf = 0; m_s1 = 0; m_s2 = 0;
            m_known = 1;
        end else begin
            pre    = m_fifo.size();
            popped = 0;
            m_irq  = m_irq_en && (pre != 0);
            if (acc && wr) begin
                case (idx)
                    3'd1: begin
                        if (PWDATA[2]) m_ovf = 0;
                        if (PWDATA[3]) m_udf = 0;
                    end
                    3'd2: m_tx = PWDATA;
                    3'd3: m_txf = PWDATA;
                    3'd5: m_irq_en = PWDATA[0];
                    default: ;
                endcase
            end
            if (acc && !wr && idx == 3'd0) begin
                if (pre == 0) m_udf = 1;
                else begin
                    void'(m_fifo.pop_front());
                    popped = 1;
                end
            end
            if (usb_data_valid_i && !m_prev) begin
                if (pre == DEPTH && !popped) m_ovf = 1;
                else m_fifo.push_back(usb_data_i);
            end
            m_s2   = m_s1;
            m_s1   = ext_flags_i;
            m_prev = usb_data_valid_i;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    always begin
        exp_t e;
        @(negedge crypto_clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (e.chk) begin
                check("pulpino_data_o", pulpino_data_o, e.data_o);
                check("pulpino_flags_o", pulpino_flags_o, e.flags_o);
                check("rx_irq_o", {31'd0, rx_irq_o}, {31'd0, e.irq});
                if (e.acc) begin
                    check("PREADY", {31'd0, PREADY}, 32'd1);
                    check("PSLVERR", {31'd0, PSLVERR}, {31'd0, e.slverr});
                    if (e.rd) check($sformatf("PRDATA@0x%03h", PADDR), PRDATA, e.prdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge crypto_clk);
        #1;
    endtask

    task automatic apb(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                       input bit strobe, input logic [31:0] sd);
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        tick();
        PENABLE = 1;
        if (strobe) begin
            usb_data_valid_i = 1;
            usb_data_i       = sd;
        end
        tick();
        PSEL = 0; PENABLE = 0;
        if (strobe) usb_data_valid_i = 0;
        tick();
    endtask

    task automatic rd(input logic [AW-1:0] addr);
        apb(0, addr, 32'd0, 0, 32'd0);
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [31:0] d);
        apb(1, addr, d, 0, 32'd0);
    endtask

    task automatic strobe(input logic [31:0] d, input int len);
        usb_data_valid_i = 1;
        usb_data_i       = d;
        repeat (len) tick();
        usb_data_valid_i = 0;
        tick();
    endtask

    task automatic fill_full(input logic [31:0] base);
        for (int i = 0; i < DEPTH; i++) strobe(base + 32'(i), 1);
    endtask

    initial begin
        int r;
        logic [AW-1:0] a;
        repeat (3) tick();
        reset_i = 0;
        tick();

        // Reset state
        rd(12'h004);
        // Multi-cycle strobe pushes once
        strobe(32'hDEADBEEF, 3);
        rd(12'h004); rd(12'h000); rd(12'h004);
        // Overflow with five pushes into depth 4, drain, W1C
        for (int i = 1; i <= 5; i++) strobe(32'(i), 1);
        rd(12'h004);
        for (int i = 0; i < 4; i++) rd(12'h000);
        wr(12'h004, 32'h4);
        rd(12'h004);
        // Full FIFO: push and pop in the same cycle
        fill_full(32'h100);
        apb(0, 12'h000, 32'd0, 1, 32'h0000_0155);
        rd(12'h004);
        for (int i = 0; i < 4; i++) rd(12'h000);
        rd(12'h004);
        // Underflow and unmapped offsets
        rd(12'h000); rd(12'h004); rd(12'h018); wr(12'h01C, 32'h1234); rd(12'h004);
        wr(12'h004, 32'hC); rd(12'h004);
        // Empty FIFO: pop judged before the simultaneous push
        apb(0, 12'h000, 32'd0, 1, 32'h77);
        rd(12'h004); rd(12'h000);
        // W1C OVERFLOW in the same cycle as a new overflow
        fill_full(32'h200);
        apb(1, 12'h004, 32'h4, 1, 32'h999);
        rd(12'h004);
        wr(12'h004, 32'hC);
        // IRQ and flag synchroniser; TX registers; RO write ignored
        wr(12'h014, 32'hFFFF_FFFF); rd(12'h014);
        strobe(32'h99, 1); tick();
        ext_flags_i = 32'hA5; tick(); tick(); tick();
        rd(12'h010);
        wr(12'h008, 32'hCAFE_F00D); wr(12'h00C, 32'h1357_9BDF); wr(12'h010, 32'h0);
        rd(12'h008); rd(12'h00C); rd(12'h010);
        for (int i = 0; i < 5; i++) rd(12'h000);
        // Reset in the middle of a strobe: one push afterwards
        usb_data_valid_i = 1; usb_data_i = 32'h55; tick();
        reset_i = 1; tick(); reset_i = 0; tick(); tick();
        usb_data_valid_i = 0; tick();
        rd(12'h004); rd(12'h000);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            a = {7'($urandom), 3'($urandom_range(0, 7)), 2'($urandom)};
            if (r < 35) strobe($urandom, $urandom_range(1, 3));
            else if (r < 55) rd({7'($urandom), 3'd0, 2'($urandom)});
            else if (r < 65) rd(a);
            else if (r < 75) apb(0, {7'($urandom), 3'd0, 2'b00}, 32'd0, 1, $urandom);
            else if (r < 90) wr(a, $urandom);
            else if (r < 95) begin
                ext_flags_i = $urandom;
                tick();
            end else if (r < 98) apb(1, 12'h004, 32'($urandom_range(0, 15)), 1, $urandom);
            else begin
                usb_data_valid_i = $urandom_range(0, 1);
                usb_data_i = $urandom;
                reset_i = 1; tick(); reset_i = 0; tick();
                usb_data_valid_i = 0; tick();
            end
        end

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
